// File: rtl/dmem_pkg.sv
// Shared definitions for the M-stage data-memory responder:
// FSM state encoding, the misaligned-read return pattern and
// the helper that sizes the word index from the storage depth.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] MISALIGN_DATA = 32'hDEAD_BEEF;

  // Word-index width for a power-of-two depth (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage: synchronous write, combinational read, one shared
// word index (the responder has a single outstanding access, so reads and
// writes never need different addresses in the same cycle).
// No reset: contents survive reset. A non-empty INIT_FILE is reported at
// elaboration because preloading must come from the memory generator /
// bitstream flow rather than from this model.
module dmem_array #(
  parameter int    DEPTH     = 256,
  parameter int    AW        = 8,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Store commits on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

  if (INIT_FILE != "") begin : g_preload_note
    $warning("dmem_array: INIT_FILE %s must be applied by the memory preload flow", INIT_FILE);
  end

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder. Accepts one load/store at a time, holds
// the pipeline with MemStallM for LATENCY cycles, then commits in the DONE
// cycle (stall low) so the M->W register captures ReadDataM at that edge.
// Optional build macro: DMEM_MISALIGN_CHECK_EN adds MemMisalignM, suppresses
// misaligned stores and returns MISALIGN_DATA for misaligned loads.
//
// Handshake: req = MemReadM | MemWriteM is a level request. While
// MemStallM is high the master must hold its inputs; the values captured in
// IDLE are what get used. Dropping req during WAIT aborts the access with
// no side effects. The DONE cycle always completes and releases the stall.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int    DEPTH     = 256,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemStallM,
  output logic [15:0] AccessCountM,
`ifdef DMEM_MISALIGN_CHECK_EN
  output logic        MemMisalignM,
`endif
  output logic [1:0]  state_dbg
);

  localparam int         AW       = idx_width(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_e        state, next_state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          write_q;
  logic          req;
  logic          blocked;
  logic          mem_we;
  logic [31:0]   rdata;
  logic [31:0]   read_val;
  logic          unused_addr_bits;

  assign req = MemReadM | MemWriteM;

  // Address bits outside the word index are deliberately ignored.
  assign unused_addr_bits = ^{ALUOutM[31:AW+2], ALUOutM[1:0]};

`ifdef DMEM_MISALIGN_CHECK_EN
  logic mis_q;

  // Misalignment flag captured with the request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mis_q <= 1'b0;
    else if (state == IDLE && req) mis_q <= (ALUOutM[1:0] != 2'b00);
  end

  assign MemMisalignM = (state == DONE) & mis_q;
  assign blocked      = mis_q;
  assign read_val     = mis_q ? MISALIGN_DATA : rdata;
`else
  assign blocked  = 1'b0;
  assign read_val = rdata;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: IDLE -> WAIT (or DONE when LATENCY is 1) -> DONE -> IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req) next_state = (LATENCY == 1) ? DONE : WAIT;
      WAIT: begin
        if (!req)           next_state = IDLE;
        else if (cnt <= 4'd1) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request capture, wait counter and the registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= 4'd0;
      idx_q        <= '0;
      wdata_q      <= 32'd0;
      write_q      <= 1'b0;
      ReadDataM    <= 32'd0;
      AccessCountM <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= ALUOutM[AW+1:2];
            wdata_q <= WriteDataM;
            write_q <= MemWriteM;
            cnt     <= CNT_LOAD;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        DONE: begin
          AccessCountM <= AccessCountM + 16'd1;
          if (!write_q) ReadDataM <= read_val;
        end
        default: cnt <= 4'd0;
      endcase
    end
  end

  assign mem_we    = (state == DONE) & write_q & ~blocked;
  assign MemStallM = reset & req & (state != DONE);
  assign state_dbg = state;

  dmem_array #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2, one at
// LATENCY=1, shared clock and reset. Expected values are hand-computed.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd0, wr0, rd1, wr1;
  logic [31:0] addr0, data0, addr1, data1;
  logic [31:0] rdata0, rdata1;
  logic        stall0, stall1;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  st0, st1;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic        mis0, mis1;
  localparam logic [31:0] EXP_20 = 32'h0000_0055;
  localparam logic [31:0] EXP_22 = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] EXP_20 = 32'h0000_0001;
  localparam logic [31:0] EXP_22 = 32'h0000_0001;
`endif

  int total = 0;
  int bad   = 0;

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #60000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  dmem_responder #(.DEPTH(256), .LATENCY(2), .INIT_FILE("")) u_dut0 (
    .clk          (clk),
    .reset        (reset),
    .MemReadM     (rd0),
    .MemWriteM    (wr0),
    .ALUOutM      (addr0),
    .WriteDataM   (data0),
    .ReadDataM    (rdata0),
    .MemStallM    (stall0),
    .AccessCountM (cnt0),
`ifdef DMEM_MISALIGN_CHECK_EN
    .MemMisalignM (mis0),
`endif
    .state_dbg    (st0)
  );

  dmem_responder #(.DEPTH(256), .LATENCY(1), .INIT_FILE("")) u_dut1 (
    .clk          (clk),
    .reset        (reset),
    .MemReadM     (rd1),
    .MemWriteM    (wr1),
    .ALUOutM      (addr1),
    .WriteDataM   (data1),
    .ReadDataM    (rdata1),
    .MemStallM    (stall1),
    .AccessCountM (cnt1),
`ifdef DMEM_MISALIGN_CHECK_EN
    .MemMisalignM (mis1),
`endif
    .state_dbg    (st1)
  );

  // Scoreboard comparison.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin rd1 = rd; wr1 = wr; addr1 = a; data1 = d; end
    else     begin rd0 = rd; wr0 = wr; addr0 = a; data0 = d; end
  endtask

  function automatic logic cur_stall(input bit sel);
    return sel ? stall1 : stall0;
  endfunction

  function automatic logic [1:0] cur_state(input bit sel);
    return sel ? st1 : st0;
  endfunction

  // One complete access: count stall cycles, check DONE, release the request.
  task automatic access(input bit sel, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input int exp_stalls, input logic exp_mis, input string tag);
    int n;
    n = 0;
    drive(sel, rd, wr, a, d);
    #1;
    while (cur_stall(sel) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_stalls"}, 32'(n), 32'(exp_stalls));
    chk({tag, "_done"}, 32'(cur_state(sel)), 32'(DONE));
`ifdef DMEM_MISALIGN_CHECK_EN
    chk({tag, "_mis"}, 32'(sel ? mis1 : mis0), 32'(exp_mis));
`else
    if (exp_mis) $display("  note: %s uses a misaligned address", tag);
`endif
    drive(sel, 1'b0, 1'b0, a, d);
    @(posedge clk); #1;
  endtask

  // Directed sequence.
  initial begin
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    #2;
    chk("rst_rdata", rdata0, 32'd0);
    chk("rst_stall", 32'(stall0), 32'd0);
    chk("rst_cnt", 32'(cnt0), 32'd0);
    chk("rst_state", 32'(st0), 32'(IDLE));
    #10 reset = 1'b1;
    @(posedge clk); #1;

    // Store then load at 0x40.
    access(0, 1'b0, 1'b1, 32'h40, 32'h1234_5678, 2, 1'b0, "st40");
    chk("st40_cnt", 32'(cnt0), 32'd1);
    access(0, 1'b1, 1'b0, 32'h40, 32'd0, 2, 1'b0, "ld40");
    chk("ld40_data", rdata0, 32'h1234_5678);
    chk("ld40_cnt", 32'(cnt0), 32'd2);

    // Address wrap: 0x400 aliases 0x000 at DEPTH=256.
    access(0, 1'b0, 1'b1, 32'h400, 32'hA5A5_A5A5, 2, 1'b0, "st400");
    access(0, 1'b1, 1'b0, 32'h000, 32'd0, 2, 1'b0, "ld000");
    chk("wrap_data", rdata0, 32'hA5A5_A5A5);
    chk("wrap_cnt", 32'(cnt0), 32'd4);

    // Flushed load.
    drive(0, 1'b1, 1'b0, 32'h40, 32'd0);
    #1;
    chk("flr_stall0", 32'(stall0), 32'd1);
    @(posedge clk); #1;
    chk("flr_wait", 32'(st0), 32'(WAIT));
    drive(0, 1'b0, 1'b0, 32'h40, 32'd0);
    @(posedge clk); #1;
    chk("flr_idle", 32'(st0), 32'(IDLE));
    chk("flr_data", rdata0, 32'hA5A5_A5A5);
    chk("flr_cnt", 32'(cnt0), 32'd4);

    // Flushed store leaves the word intact.
    drive(0, 1'b0, 1'b1, 32'h40, 32'hDEAD_DEAD);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h40, 32'd0);
    @(posedge clk); #1;
    chk("flw_idle", 32'(st0), 32'(IDLE));
    chk("flw_cnt", 32'(cnt0), 32'd4);
    access(0, 1'b1, 1'b0, 32'h40, 32'd0, 2, 1'b0, "ld40b");
    chk("flw_data", rdata0, 32'h1234_5678);
    chk("flw_cnt2", 32'(cnt0), 32'd5);

    // Both strobes: treated as a store, ReadDataM holds.
    access(0, 1'b1, 1'b1, 32'h10, 32'd7, 2, 1'b0, "both");
    chk("both_hold", rdata0, 32'h1234_5678);
    chk("both_cnt", 32'(cnt0), 32'd6);
    access(0, 1'b1, 1'b0, 32'h10, 32'd0, 2, 1'b0, "ld10");
    chk("both_data", rdata0, 32'd7);
    chk("ld10_cnt", 32'(cnt0), 32'd7);

    access(0, 1'b0, 1'b1, 32'h80, 32'h1111_2222, 2, 1'b0, "st80");
    chk("st80_cnt", 32'(cnt0), 32'd8);

    // Asynchronous reset in the middle of a load.
    drive(0, 1'b1, 1'b0, 32'h80, 32'd0);
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    chk("mrst_rdata", rdata0, 32'd0);
    chk("mrst_stall", 32'(stall0), 32'd0);
    chk("mrst_cnt", 32'(cnt0), 32'd0);
    chk("mrst_state", 32'(st0), 32'(IDLE));
    drive(0, 1'b0, 1'b0, 32'h80, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a store: nothing is committed.
    drive(0, 1'b0, 1'b1, 32'h80, 32'h3333_4444);
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    drive(0, 1'b0, 1'b0, 32'h80, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    access(0, 1'b1, 1'b0, 32'h80, 32'd0, 2, 1'b0, "ld80");
    chk("rstw_data", rdata0, 32'h1111_2222);
    chk("rstw_cnt", 32'(cnt0), 32'd1);

    // LATENCY=1 instance, low address bits.
    access(1, 1'b0, 1'b1, 32'h20, 32'h55, 1, 1'b0, "l1_st20");
    chk("l1_cnt1", 32'(cnt1), 32'd1);
    access(1, 1'b0, 1'b1, 32'h22, 32'h1, 1, 1'b1, "l1_st22");
    chk("l1_cnt2", 32'(cnt1), 32'd2);
    access(1, 1'b1, 1'b0, 32'h20, 32'd0, 1, 1'b0, "l1_ld20");
    chk("l1_ld20_data", rdata1, EXP_20);
    access(1, 1'b1, 1'b0, 32'h22, 32'd0, 1, 1'b1, "l1_ld22");
    chk("l1_ld22_data", rdata1, EXP_22);
    chk("l1_cnt4", 32'(cnt1), 32'd4);
    chk("l1_idle", 32'(st1), 32'(IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-stage data-memory responder: the slave end of the pipeline's M-stage load/store interface.
- Accepts address `ALUOutM`, write data `WriteDataM` and read/write strobes, and returns `ReadDataM`.
- Inserts a programmable number of wait states, signalled through `MemStallM`; the hazard unit uses it to freeze F/D/E/M and bubble W.
- Word-addressed, 32-bit, single outstanding access.

Parameters:
- `DEPTH`, 256, number of 32-bit words in storage (power of two).
- `LATENCY`, 2, stall cycles per access; legal range 1..15.
- `INIT_FILE`, "", optional `$readmemh` image for the storage array; empty means no preload.

Ports:
- `clk` input 1 — rising-edge clock.
- `reset` input 1 — asynchronous, active-low reset (asserted when 0).
- `MemReadM` input 1 — load request in M stage.
- `MemWriteM` input 1 — store request in M stage.
- `ALUOutM` input 32 — byte address.
- `WriteDataM` input 32 — store data.
- `ReadDataM` output 32 — load data, registered.
- `MemStallM` output 1 — pipeline must hold M-stage inputs stable.
- `AccessCountM` output 16 — completed-access counter, wrapping.

Behaviour:
- Reset (`reset`=0, asynchronous): state=IDLE, wait counter=0, `ReadDataM`=0, `AccessCountM`=0, `MemStallM`=0. The storage array is not cleared.
- Index = `ALUOutM[log2(DEPTH)+1:2]`. Upper bits are ignored, so addresses wrap modulo `DEPTH`×4. `ALUOutM[1:0]` is ignored.
- `req` = `MemReadM` | `MemWriteM`.
- FSM states: IDLE, WAIT, DONE.
  - IDLE:
    - req=1: capture index, write data and op; load counter with `LATENCY`-1; go to WAIT, or to DONE if `LATENCY`=1.
    - req=0: stay in IDLE.
  - WAIT: decrement counter; go to DONE when it reaches 0.
  - DONE:
    - Commit the operation at the closing edge: a write updates the array; a read loads `ReadDataM`.
    - `AccessCountM` increments.
    - Next state = IDLE.
- `MemStallM` (combinational) = req & (state != DONE).
  - The pipeline stalls exactly `LATENCY` cycles per access.
  - Stall is low in the DONE cycle so the M→W register captures the result at that edge.
- `ReadDataM` changes only on completion of a read; otherwise it holds its last value.
- Both strobes high: treated as a write; `ReadDataM` is not updated.
- Request dropped while in WAIT (flush or pipeline reset): abort to IDLE, no array write, no count increment.
- Request inputs changing while stalled is a protocol violation. The captured values are used.
- Back-to-back accesses: the next access starts in IDLE the cycle after DONE, so there is no gap beyond the FSM return.
- Reset asserted mid-access: the access is lost and no write is committed.

Optional Feature:
- Macro: `DMEM_MISALIGN_CHECK_EN`.
- With the macro:
  - Add output `MemMisalignM` (1 bit, reset 0).
  - It is asserted in the DONE cycle of any access whose captured `ALUOutM[1:0]` != 0.
  - Misaligned writes are suppressed (array unchanged). Misaligned reads return 32'hDEAD_BEEF.
- Without the macro: the port is absent and the low address bits are silently ignored.

Decomposition:
- Package `dmem_pkg` holds:
  - state encoding: IDLE=2'd0, WAIT=2'd1, DONE=2'd2;
  - `MISALIGN_DATA` constant 32'hDEAD_BEEF;
  - the function deriving index width from `DEPTH`.
- Sub-module `dmem_array`: synchronous-write storage (`DEPTH`×32, `INIT_FILE` preload) with combinational read port. The FSM, counter and output registers stay in the top.

Test Plan:
1. Reset: drive `reset`=0 mid-sim with `MemReadM`=1 → `ReadDataM`=0, `MemStallM`=0, `AccessCountM`=0 immediately, without waiting for a clock edge.
2. `LATENCY`=2:
   - store 32'h1234_5678 to 0x40 → `MemStallM` high 2 cycles then low 1 cycle, count=1;
   - then load 0x40 → `ReadDataM`=32'h1234_5678 after 2 stall cycles, count=2.
3. Wrap: `DEPTH`=256, store 32'hA5A5_A5A5 to 0x400 → load from 0x000 returns 32'hA5A5_A5A5.
4. Flush: start load, drop `MemReadM` after 1 stall cycle → FSM returns to IDLE, `ReadDataM` unchanged, count unchanged. Repeating with a store leaves the array unchanged.
5. Simultaneous strobes: `MemReadM`=`MemWriteM`=1 at 0x10 with data 7 → array[4]=7, `ReadDataM` holds its prior value.
6. `LATENCY`=1 and `DMEM_MISALIGN_CHECK_EN` defined:
   - store 32'h1 to 0x22 → 1 stall cycle, `MemMisalignM`=1, memory unchanged;
   - load 0x22 → `ReadDataM`=32'hDEAD_BEEF.
